spi_tx_arbiter: RTL and testbench
=================================

Name: spi_tx_arbiter

Overview:
- Shares the single SPI transmit driver (AXI-Lite → AXI SPI core) among NUM_REQ independent requesters, for example filter output, error signal and coefficient dump.
- Each requester has a one-word holding buffer. Words are granted round-robin and framed with an 8-bit header {seq, id}.
- Issues one tx_en pulse per word and waits for the driver's write-complete pulse before the next grant.
- A watchdog recovers from a driver that never completes.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- DATA_W, 24, requester payload width; legal range 1..24; zero-extended to 24 bits.
- TIMEOUT, 1024, cycles allowed in WAIT for drv_done before abort; must be ≥ 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- req_valid  in  NUM_REQ  per-requester word valid
- req_data  in  NUM_REQ*DATA_W  payloads; requester i uses bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  holding buffer i is empty
- tx_en  out  1  one-cycle send strobe to the SPI driver
- tx_data  out  32  framed word to the SPI driver
- drv_done  in  1  one-cycle pulse from the driver on every completed AXI write, including the post-reset SPICR config write
- busy  out  1  high in ISSUE or WAIT
- grant_id  out  4  index of the most recently granted requester
- tx_count  out  16  count of words completed with drv_done; wraps 0xFFFF→0
- timeout_err  out  1  sticky; set on any watchdog abort

Behaviour:
- Reset values:
  - state = INIT
  - all buffers empty; req_ready = 0 while in INIT
  - tx_en = 0, tx_data = 0, busy = 0, grant_id = 0, tx_count = 0, timeout_err = 0
  - seq = 0; round-robin pointer last = NUM_REQ-1, so requester 0 wins first
- Buffers:
  - req_ready[i] = !buf_full[i] && state != INIT.
  - Accept on req_valid[i] && req_ready[i]; buf_full[i] is set the next cycle.
  - A buffer is cleared on the clock edge that leaves ISSUE for the granted index.
- State machine:
  - INIT: wait for the first drv_done, which marks the driver's config write complete. Then go to IDLE. Nothing is issued before this.
  - IDLE: if any buf_full, pick the first full index searching last+1, last+2, … modulo NUM_REQ. Register grant_id and last = that index, then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: exactly one cycle.
    - tx_en = 1.
    - tx_data = {seq[3:0], grant_id[3:0], zero-extended payload[23:0]}.
    - Increment seq, wrapping 15→0.
    - Clear the buffer, reset the watchdog to 0, go to WAIT.
  - WAIT:
    - On drv_done: tx_count++, go to IDLE.
    - Else, if the watchdog reaches TIMEOUT-1: set timeout_err, go to IDLE. The word is dropped, tx_count is unchanged, and seq is not rewound.
    - Else the watchdog increments.
- Outputs outside ISSUE: tx_en = 0; tx_data holds its last value.
- Latency: a word accepted at edge t has tx_en high in the cycle after edge t+2, provided the arbiter is in IDLE with no competitors.
- Throughput: at most one word per (3 + driver latency) cycles.
- drv_done outside INIT/WAIT is ignored; it does not count and does not change state.
- drv_done and watchdog expiry in the same cycle: done wins, no error.
- A requester that refills its buffer while its previous word is in WAIT is not re-granted until every other full buffer has been served. This is strict round-robin with no starvation.
- Reset mid-operation, in any state:
  - Buffered words are discarded and every register returns to its reset value.
  - The state returns to INIT and re-waits for the driver's new config-write drv_done.
- timeout_err clears only on reset.

Test Plan:
- Startup: assert req_valid[0] with data 0xABCDEF immediately after reset. No tx_en until drv_done is pulsed once. Then tx_en fires once with tx_data = 0x00ABCDEF, and req_ready[0] is 0 throughout INIT.
- Round-robin: fill all 4 buffers simultaneously with 0x000001..0x000004 for i = 0..3, and pulse drv_done 5 cycles after each tx_en. Expect tx_data = 0x00000001, 0x11000002, 0x22000003, 0x33000004 in that order, and tx_count = 4.
- Fairness: requester 1 refills continuously while requester 3 has one word. After requester 1 is served, requester 3 is served next (grant_id sequence 1, 3, 1).
- Sequence wrap: send 17 words from requester 2. The header of word 17 is 0x02 (seq wrapped 15→0), and tx_count = 17.
- Timeout: with TIMEOUT=16, never pulse drv_done after a tx_en. Exactly 16 cycles after ISSUE the block returns to IDLE with timeout_err = 1 and tx_count unchanged. The next buffered word is issued normally.
- Reset mid-WAIT: assert rst_n = 0 for one cycle during WAIT with buffers full. All outputs return to reset values and state is INIT. A stray drv_done before the config-write drv_done is treated as the init pulse; verify no tx_en occurs before it.

Source files
------------

// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter that shares one SPI transmit driver among NUM_REQ requesters.
// Each word is framed with a {seq, id} header and the arbiter waits for the driver's write-complete pulse.
module spi_tx_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 24,
   parameter int TIMEOUT = 1024
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      tx_en,
   output logic [31:0]               tx_data,
   input  logic                      drv_done,
   output logic                      busy,
   output logic [3:0]                grant_id,
   output logic [15:0]               tx_count,
   output logic                      timeout_err
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WD_W  = $clog2(TIMEOUT);

   localparam logic [1:0] ST_INIT  = 2'd0;
   localparam logic [1:0] ST_IDLE  = 2'd1;
   localparam logic [1:0] ST_ISSUE = 2'd2;
   localparam logic [1:0] ST_WAIT  = 2'd3;

   localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);
   localparam logic [IDX_W:0]   ONE       = 1;

   logic [1:0]         state;
   logic [NUM_REQ-1:0] buf_full;
   logic [DATA_W-1:0]  buf_data [NUM_REQ];
   logic [IDX_W-1:0]   grant_idx;
   logic [IDX_W-1:0]   last;
   logic [3:0]         seq;
   logic [WD_W-1:0]    wd;

   logic [IDX_W:0]     shamt;
   logic [NUM_REQ-1:0] rot;
   logic               pick_found;
   logic [IDX_W-1:0]   pick_idx;

   assign req_ready = (state != ST_INIT) ? ~buf_full : '0;
   assign busy      = (state == ST_ISSUE) || (state == ST_WAIT);
   assign grant_id  = 4'(grant_idx);

   // Rotate the full flags so bit 0 is the requester just after the last grant;
   // the lowest set bit of the rotated vector is then the round-robin winner.
   always_comb begin
      shamt      = {1'b0, last} + ONE;
      rot        = NUM_REQ'({buf_full, buf_full} >> shamt);
      pick_found = 1'b0;
      pick_idx   = last;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!pick_found && rot[j]) begin
            pick_found = 1'b1;
            pick_idx   = IDX_W'((int'(last) + 1 + j) % NUM_REQ);
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_valid[i] && req_ready[i]) begin
            buf_data[i] <= req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_INIT;
         buf_full    <= '0;
         tx_en       <= 1'b0;
         tx_data     <= '0;
         grant_idx   <= '0;
         last        <= LAST_INIT;
         seq         <= '0;
         wd          <= '0;
         tx_count    <= '0;
         timeout_err <= 1'b0;
      end else begin
         tx_en <= 1'b0;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               buf_full[i] <= 1'b1;
            end
         end
         case (state)
            // The first drv_done after reset is the driver's own config write.
            ST_INIT: begin
               if (drv_done) begin
                  state <= ST_IDLE;
               end
            end
            ST_IDLE: begin
               if (pick_found) begin
                  grant_idx <= pick_idx;
                  last      <= pick_idx;
                  state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               tx_en               <= 1'b1;
               tx_data             <= {seq, 4'(grant_idx), 24'(buf_data[grant_idx])};
               seq                 <= seq + 4'd1;
               buf_full[grant_idx] <= 1'b0;
               wd                  <= '0;
               state               <= ST_WAIT;
            end
            // A completion in the same cycle as watchdog expiry is taken as success.
            ST_WAIT: begin
               if (drv_done) begin
                  tx_count <= tx_count + 16'd1;
                  state    <= ST_IDLE;
               end else if (wd == WD_LAST) begin
                  timeout_err <= 1'b1;
                  state       <= ST_IDLE;
               end else begin
                  wd <= wd + 1'b1;
               end
            end
            default: state <= ST_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Testbench for spi_tx_arbiter: directed scenarios followed by random traffic,
// compared against a transaction-level round-robin reference model.
module tb_spi_tx_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 24;
   localparam int TIMEOUT = 16;

   logic                      clk = 1'b0;
   logic                      rst_n = 1'b0;
   logic [NUM_REQ-1:0]        req_valid = '0;
   logic [NUM_REQ*DATA_W-1:0] req_data = '0;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      tx_en;
   logic [31:0]               tx_data;
   logic                      drv_done = 1'b0;
   logic                      busy;
   logic [3:0]                grant_id;
   logic [15:0]               tx_count;
   logic                      timeout_err;

   int total = 0;
   int bad   = 0;

   // Reference model: buffer contents, round-robin pointer, header sequence and counters.
   logic [3:0]  m_full;
   logic [23:0] m_data [NUM_REQ];
   int          m_last;
   logic [3:0]  m_seq;
   logic [15:0] m_count;
   logic        m_err;

   logic [31:0] rr_exp [4];
   int          g_exp  [3];

   spi_tx_arbiter #(
      .NUM_REQ(NUM_REQ),
      .DATA_W (DATA_W),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .tx_en      (tx_en),
      .tx_data    (tx_data),
      .drv_done   (drv_done),
      .busy       (busy),
      .grant_id   (grant_id),
      .tx_count   (tx_count),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic modelReset();
      m_full  = '0;
      m_last  = NUM_REQ - 1;
      m_seq   = '0;
      m_count = '0;
      m_err   = 1'b0;
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_tx_en"},   32'(tx_en), 32'd0);
      checkOutput({tag, "_tx_data"}, tx_data, 32'd0);
      checkOutput({tag, "_busy"},    32'(busy), 32'd0);
      checkOutput({tag, "_grant"},   32'(grant_id), 32'd0);
      checkOutput({tag, "_count"},   32'(tx_count), 32'd0);
      checkOutput({tag, "_terr"},    32'(timeout_err), 32'd0);
      checkOutput({tag, "_ready"},   32'(req_ready), 32'd0);
   endtask

   // One clock of rst_n low; the model forgets everything with it.
   task automatic doReset(input string tag);
      @(negedge clk);
      rst_n     = 1'b0;
      req_valid = '0;
      drv_done  = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      modelReset();
      checkReset(tag);
   endtask

   task automatic pulseDone();
      drv_done = 1'b1;
      @(negedge clk);
      drv_done = 1'b0;
   endtask

   task automatic completeWord();
      pulseDone();
      m_count = m_count + 16'd1;
   endtask

   // Offers one word to each masked (empty) requester for a single cycle.
   task automatic applyStimulus(input logic [3:0] mask, input logic [NUM_REQ*DATA_W-1:0] data);
      for (int i = 0; i < NUM_REQ; i++) begin
         if (mask[i]) begin
            checkOutput($sformatf("ready%0d", i), 32'(req_ready[i]), 32'(!m_full[i]));
         end
      end
      req_valid = mask;
      req_data  = data;
      @(negedge clk);
      req_valid = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (mask[i]) begin
            m_full[i] = 1'b1;
            m_data[i] = data[i*DATA_W +: DATA_W];
         end
      end
   endtask

   // Waits for the next tx_en and checks it against the model's round-robin choice.
   task automatic expectTx(input string tag);
      int n = 0;
      int g = -1;
      do begin
         @(negedge clk);
         n++;
      end while (tx_en !== 1'b1 && n < 12);
      if (tx_en !== 1'b1) begin
         checkOutput({tag, "_tx_en_timeout"}, 32'(tx_en), 32'd1);
      end else begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            if (g < 0 && m_full[(m_last + k) % NUM_REQ]) begin
               g = (m_last + k) % NUM_REQ;
            end
         end
         if (g < 0) begin
            checkOutput({tag, "_unexpected_tx"}, 32'(tx_en), 32'd0);
         end else begin
            checkOutput({tag, "_tx_data"}, tx_data, {m_seq, 4'(g), m_data[g]});
            checkOutput({tag, "_grant"}, 32'(grant_id), 32'(g));
            checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
            m_last    = g;
            m_seq     = m_seq + 4'd1;
            m_full[g] = 1'b0;
         end
      end
   endtask

   initial begin
      logic [3:0] fill;
      modelReset();
      rr_exp = '{32'h00000001, 32'h11000002, 32'h22000003, 32'h33000004};
      g_exp  = '{1, 3, 1};

      // Startup: nothing leaves before the driver's config-write completion.
      doReset("rst0");
      req_valid = 4'b0001;
      req_data  = 96'hABCDEF;
      repeat (5) begin
         @(negedge clk);
         checkOutput("init_ready0", 32'(req_ready[0]), 32'd0);
         checkOutput("init_no_tx", 32'(tx_en), 32'd0);
      end
      pulseDone();
      checkOutput("init_ready_after", 32'(req_ready[0]), 32'd1);
      @(negedge clk);
      req_valid = '0;
      m_full[0] = 1'b1;
      m_data[0] = 24'hABCDEF;
      expectTx("startup");
      checkOutput("startup_lit", tx_data, 32'h00ABCDEF);
      repeat (2) @(negedge clk);
      completeWord();
      checkOutput("startup_count", 32'(tx_count), 32'(m_count));

      // Round-robin from a fresh reset.
      doReset("rst1");
      pulseDone();
      applyStimulus(4'b1111, {24'd4, 24'd3, 24'd2, 24'd1});
      for (int w = 0; w < 4; w++) begin
         expectTx("rr");
         checkOutput($sformatf("rr_lit%0d", w), tx_data, rr_exp[w]);
         repeat (5) @(negedge clk);
         completeWord();
      end
      checkOutput("rr_count", 32'(tx_count), 32'd4);

      // Fairness: requester 1 refills during its own WAIT, requester 3 still goes next.
      applyStimulus(4'b1010, {24'h333, 24'h0, 24'h111, 24'h0});
      for (int w = 0; w < 3; w++) begin
         expectTx("fair");
         checkOutput($sformatf("fair_grant%0d", w), 32'(grant_id), 32'(g_exp[w]));
         if (w == 0) begin
            applyStimulus(4'b0010, {24'h0, 24'h0, 24'h112, 24'h0});
         end
         completeWord();
      end

      // drv_done while idle is ignored.
      pulseDone();
      repeat (2) @(negedge clk);
      checkOutput("stray_done_count", 32'(tx_count), 32'(m_count));
      checkOutput("stray_done_busy", 32'(busy), 32'd0);

      // Sequence wrap over 17 words.
      doReset("rst2");
      pulseDone();
      for (int w = 1; w <= 17; w++) begin
         applyStimulus(4'b0100, 96'(w) << 48);
         expectTx("wrap");
         if (w == 17) begin
            checkOutput("wrap_header", 32'(tx_data[31:24]), 32'h02);
         end
         @(negedge clk);
         completeWord();
      end
      checkOutput("wrap_count", 32'(tx_count), 32'd17);

      // Watchdog: exactly TIMEOUT cycles in WAIT, then the next word goes out normally.
      applyStimulus(4'b0011, {24'h0, 24'h0, 24'h0000B1, 24'h0000A0});
      expectTx("tmo_first");
      repeat (TIMEOUT - 1) @(negedge clk);
      checkOutput("tmo_busy_last", 32'(busy), 32'd1);
      checkOutput("tmo_err_before", 32'(timeout_err), 32'd0);
      @(negedge clk);
      m_err = 1'b1;
      checkOutput("tmo_busy_after", 32'(busy), 32'd0);
      checkOutput("tmo_err_after", 32'(timeout_err), 32'(m_err));
      checkOutput("tmo_count", 32'(tx_count), 32'(m_count));
      expectTx("tmo_next");
      completeWord();
      checkOutput("tmo_count2", 32'(tx_count), 32'(m_count));
      checkOutput("tmo_err_sticky", 32'(timeout_err), 32'd1);

      // Reset during WAIT with every buffer full.
      applyStimulus(4'b1111, {24'hD4, 24'hC3, 24'hB2, 24'hA1});
      expectTx("rstw");
      @(negedge clk);
      doReset("rst3");
      repeat (4) begin
         @(negedge clk);
         checkOutput("rstw_no_tx", 32'(tx_en), 32'd0);
         checkOutput("rstw_ready", 32'(req_ready), 32'd0);
      end
      pulseDone();
      repeat (6) begin
         @(negedge clk);
         checkOutput("rstw_discard_tx", 32'(tx_en), 32'd0);
         checkOutput("rstw_discard_busy", 32'(busy), 32'd0);
      end
      checkOutput("rstw_ready_open", 32'(req_ready), 32'hF);

      // Random traffic with refills during WAIT and occasional driver stalls.
      for (int r = 0; r < 80; r++) begin
         if (m_full == 4'b0000) begin
            applyStimulus(4'($urandom_range(1, 15)), 96'({$urandom(), $urandom(), $urandom()}));
         end
         expectTx("rnd");
         fill = 4'($urandom_range(0, 15)) & ~m_full;
         if (fill != 4'b0000) begin
            applyStimulus(fill, 96'({$urandom(), $urandom(), $urandom()}));
         end else begin
            @(negedge clk);
         end
         checkOutput("rnd_tx_en_pulse", 32'(tx_en), 32'd0);
         if ($urandom_range(0, 7) == 0) begin
            repeat (TIMEOUT) @(negedge clk);
            m_err = 1'b1;
         end else begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            completeWord();
         end
         checkOutput("rnd_count", 32'(tx_count), 32'(m_count));
         checkOutput("rnd_terr", 32'(timeout_err), 32'(m_err));
      end

      for (int i = 0; i < NUM_REQ; i++) begin
         if (m_full != 4'b0000) begin
            expectTx("drain");
            completeWord();
         end
      end
      repeat (6) begin
         @(negedge clk);
         checkOutput("drain_quiet", 32'(tx_en), 32'd0);
      end
      checkOutput("drain_count", 32'(tx_count), 32'(m_count));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
